// File: rtl/pov_pkg.sv
// Shared types and default constants for the POV display pipeline.
// The glyph renderer sizes its column address from POV_PIX_SHIFT.
package pov_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    STALLED  = 2'd3
  } sched_state_t;

  localparam int          POV_CNT_W      = 28;
  localparam int          POV_PIX_SHIFT  = 7;
  localparam logic [27:0] POV_MIN_PERIOD = 28'd100000;
  localparam logic [27:0] POV_MAX_PERIOD = 28'd200000000;

endpackage

// File: rtl/index_sync.sv
// Two-flop synchronizer plus falling-edge detector for an asynchronous,
// idle-high board input; emits one registered pulse per high-to-low transition.
module index_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall_evt
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Resynchronize the input and register a one-cycle pulse on its falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
      fall_evt  <= 1'b0;
    end else begin
      sync_1    <= async_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      fall_evt  <= sync_prev & ~sync_2;
    end
  end

endmodule

// File: rtl/pov_pixel_scheduler.sv
// Speed-adaptive pixel clock for the POV display: measures the revolution period
// from the encoder index and strobes one column per 1/2**PIX_SHIFT revolution.
module pov_pixel_scheduler
  import pov_pkg::*;
#(
  parameter int               CNT_W      = POV_CNT_W,
  parameter int               PIX_SHIFT  = POV_PIX_SHIFT,
  parameter logic [CNT_W-1:0] MIN_PERIOD = POV_MIN_PERIOD,
  parameter logic [CNT_W-1:0] MAX_PERIOD = POV_MAX_PERIOD
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 index_n,
  output logic                 pixel_tick,
  output logic [PIX_SHIFT-1:0] column,
  output logic                 write_data,
  output logic [CNT_W-1:0]     period,
  output logic                 locked,
  output logic                 stalled
);

  localparam logic [PIX_SHIFT-1:0] LAST_COL = {PIX_SHIFT{1'b1}};
  localparam logic [PIX_SHIFT-1:0] COL_ONE  = {{(PIX_SHIFT-1){1'b0}}, 1'b1};
  localparam logic [PIX_SHIFT-1:0] COL_ZERO = {PIX_SHIFT{1'b0}};
  localparam logic [CNT_W-1:0]     ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     ZERO     = {CNT_W{1'b0}};

  sched_state_t         state;
  sched_state_t         state_next;
  logic                 idx_evt;
  logic                 at_max;
  logic                 accept;
  logic                 wrap;
  logic                 run;
  logic                 run_next;
  logic                 tick_next;
  logic [CNT_W-1:0]     rev_cnt;
  logic [CNT_W-1:0]     rev_next;
  logic [CNT_W-1:0]     interval;
  logic [CNT_W-1:0]     pix_cnt;
  logic [CNT_W-1:0]     pix_next;
  logic [CNT_W-1:0]     quot;
  logic [PIX_SHIFT-1:0] col_next;

  index_sync u_index_sync (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .async_in (index_n),
    .fall_evt (idx_evt)
  );

  // Qualify the index against the legal period window and detect column wrap
  always_comb begin
    quot   = rev_cnt >> PIX_SHIFT;
    at_max = (rev_cnt == MAX_PERIOD);
    accept = idx_evt && !at_max && (rev_cnt >= MIN_PERIOD);
    wrap   = run && (pix_cnt == interval - ONE);
  end

  // The cycle after an accepted index is cycle 1 of the new revolution, so the
  // count at the next index equals the index spacing. An index arriving while
  // saturated is not accepted but restarts the measurement out of a stall.
  always_comb begin
    if (accept || (idx_evt && at_max)) begin
      rev_next = ONE;
    end else if (at_max) begin
      rev_next = rev_cnt;
    end else begin
      rev_next = rev_cnt + ONE;
    end
  end

  // Scheduler state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
    end else begin
      state <= state_next;
    end
  end

  // Next state: saturation overrides a coincident index
  always_comb begin
    state_next = state;
    if (at_max) begin
      state_next = STALLED;
    end else if (accept) begin
      case (state)
        UNLOCKED: state_next = ACQUIRE;
        ACQUIRE:  state_next = LOCKED;
        LOCKED:   state_next = LOCKED;
        STALLED:  state_next = ACQUIRE;
        default:  state_next = UNLOCKED;
      endcase
    end else begin
      state_next = state;
    end
  end

  // Column sequencer. Entering LOCKED from ACQUIRE arms column 0 silently;
  // ticks start with the first index seen while already locked.
  always_comb begin
    tick_next = 1'b0;
    col_next  = column;
    pix_next  = pix_cnt;
    run_next  = run;
    if (state_next != LOCKED) begin
      run_next = 1'b0;
      pix_next = ZERO;
    end else if (accept && (state == LOCKED)) begin
      tick_next = 1'b1;
      col_next  = COL_ZERO;
      pix_next  = ZERO;
      run_next  = 1'b1;
    end else if (accept) begin
      col_next = COL_ZERO;
      pix_next = ZERO;
      run_next = 1'b0;
    end else if (wrap) begin
      pix_next = ZERO;
      if (column != LAST_COL) begin
        col_next  = column + COL_ONE;
        tick_next = 1'b1;
      end else begin
        run_next = 1'b0;
      end
    end else if (run) begin
      pix_next = pix_cnt + ONE;
    end else begin
      pix_next = pix_cnt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_cnt    <= ZERO;
      period     <= ZERO;
      interval   <= ZERO;
      pix_cnt    <= ZERO;
      run        <= 1'b0;
      column     <= COL_ZERO;
      pixel_tick <= 1'b0;
      write_data <= 1'b0;
      locked     <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      rev_cnt <= rev_next;
      if (accept) begin
        period   <= rev_cnt;
        interval <= (quot == ZERO) ? ONE : quot;
      end
      pix_cnt    <= pix_next;
      run        <= run_next;
      column     <= col_next;
      pixel_tick <= tick_next;
      write_data <= pixel_tick;
      locked     <= (state_next == LOCKED);
      stalled    <= (state_next == STALLED);
    end
  end

endmodule

// File: tb/tb_pov_pixel_scheduler.sv
// Directed bench for pov_pixel_scheduler with PIX_SHIFT=3, MIN_PERIOD=16,
// MAX_PERIOD=4096; expected tick times are derived from index fall times.
module tb_pov_pixel_scheduler;

  logic        sys_clk;
  logic        rst_n;
  logic        index_n;
  logic        pixel_tick;
  logic [2:0]  column;
  logic        write_data;
  logic [27:0] period;
  logic        locked;
  logic        stalled;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_fall;
  int base_a;
  int base_b;

  int tick_cyc[$];
  int tick_col[$];
  int wd_cyc[$];

  pov_pixel_scheduler #(
    .CNT_W      (28),
    .PIX_SHIFT  (3),
    .MIN_PERIOD (28'd16),
    .MAX_PERIOD (28'd4096)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .index_n    (index_n),
    .pixel_tick (pixel_tick),
    .column     (column),
    .write_data (write_data),
    .period     (period),
    .locked     (locked),
    .stalled    (stalled)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe log, sampled on the falling edge
  always @(negedge sys_clk) begin
    if (pixel_tick === 1'b1) begin
      tick_cyc.push_back(cyc);
      tick_col.push_back(int'(column));
    end
    if (write_data === 1'b1) wd_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Index low for 5 cycles; the next fall comes 'spacing' cycles after this one
  task automatic pulse(input int spacing);
    index_n   = 1'b0;
    last_fall = cyc;
    wait_cyc(5);
    index_n = 1'b1;
    wait_cyc(spacing - 5);
  endtask

  task automatic clear_log();
    tick_cyc.delete();
    tick_col.delete();
    wd_cyc.delete();
  endtask

  // Column c of a revolution whose index fell at 'base' ticks at base+4+c*intv
  task automatic expect_rev(input string tag, input int base, input int intv, input int ncols);
    int t;
    int col;
    int w;
    check({tag, "_avail"}, ((tick_cyc.size() >= ncols) && (wd_cyc.size() >= ncols)) ? 64'd1 : 64'd0, 64'd1);
    for (int c = 0; c < ncols; c++) begin
      if ((tick_cyc.size() > 0) && (wd_cyc.size() > 0)) begin
        t   = tick_cyc.pop_front();
        col = tick_col.pop_front();
        w   = wd_cyc.pop_front();
        check({tag, "_tick_cyc"}, 64'(t), 64'(base + 4 + intv * c));
        check({tag, "_column"}, 64'(col), 64'(c));
        check({tag, "_wd_cyc"}, 64'(w), 64'(t + 1));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_tick"}, 64'(pixel_tick), 64'd0);
    check({tag, "_write_data"}, 64'(write_data), 64'd0);
    check({tag, "_column"}, 64'(column), 64'd0);
    check({tag, "_period"}, 64'(period), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_stalled"}, 64'(stalled), 64'd0);
  endtask

  initial begin
    index_n = 1'b1;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    wait_cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(20);

    // Lock-in at 800-cycle spacing
    clear_log();
    pulse(800);
    pulse(800);
    check("lock_no_tick", 64'(tick_cyc.size()), 64'd0);
    check("lock_locked", 64'(locked), 64'd1);
    check("lock_period", 64'(period), 64'd800);
    pulse(800);
    base_a = last_fall;
    expect_rev("lock", base_a, 100, 8);
    check("lock_quiet_after_col7", 64'(tick_cyc.size()), 64'd0);

    // Speed change: early index at 400 restarts column 0 once
    pulse(400);
    base_a = last_fall;
    pulse(400);
    base_b = last_fall;
    expect_rev("early", base_a, 100, 4);
    expect_rev("speed", base_b, 50, 8);
    check("speed_extra", 64'(tick_cyc.size()), 64'd0);
    check("speed_period", 64'(period), 64'd400);

    // Glitch 10 cycles after a valid index
    index_n   = 1'b0;
    last_fall = cyc;
    base_a    = cyc;
    wait_cyc(5);
    index_n = 1'b1;
    wait_cyc(5);
    index_n = 1'b0;
    wait_cyc(2);
    index_n = 1'b1;
    wait_cyc(388);
    expect_rev("glitch", base_a, 50, 8);
    check("glitch_extra", 64'(tick_cyc.size()), 64'd0);
    check("glitch_period", 64'(period), 64'd400);

    // Odd period 803 -> interval 100, then index on the column 4->5 wrap
    pulse(803);
    clear_log();
    pulse(500);
    base_a = last_fall;
    check("odd_period", 64'(period), 64'd803);
    index_n   = 1'b0;
    last_fall = cyc;
    base_b    = cyc;
    wait_cyc(5);
    index_n = 1'b1;
    wait_cyc(246);
    expect_rev("odd", base_a, 100, 5);
    expect_rev("collide", base_b, 62, 4);
    check("collide_extra", 64'(tick_cyc.size()), 64'd0);
    check("collide_period", 64'(period), 64'd500);

    // Reset during the column 4 strobe
    wait_cyc(1);
    check("pre_reset_tick", 64'(pixel_tick), 64'd1);
    check("pre_reset_column", 64'(column), 64'd4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    wait_cyc(2);
    rst_n = 1'b1;
    clear_log();
    wait_cyc(200);
    pulse(800);
    pulse(800);
    check("relock_no_wd", 64'(wd_cyc.size()), 64'd0);
    check("relock_no_tick", 64'(tick_cyc.size()), 64'd0);
    check("relock_locked", 64'(locked), 64'd1);

    // Stall: counter saturates 4095 cycles after the accept edge
    base_a = last_fall;
    wait_cyc(base_a + 4099 - cyc);
    check("prestall_stalled", 64'(stalled), 64'd0);
    check("prestall_locked", 64'(locked), 64'd1);
    wait_cyc(1);
    check("stall_stalled", 64'(stalled), 64'd1);
    check("stall_locked", 64'(locked), 64'd0);
    check("stall_no_tick", 64'(tick_cyc.size()), 64'd0);

    // Resume: saturated index restarts timing, two accepted indexes relock
    pulse(800);
    check("resume1_stalled", 64'(stalled), 64'd1);
    pulse(800);
    check("resume2_stalled", 64'(stalled), 64'd0);
    check("resume2_locked", 64'(locked), 64'd0);
    pulse(800);
    check("resume3_locked", 64'(locked), 64'd1);
    check("resume3_period", 64'(period), 64'd800);
    check("resume3_no_tick", 64'(tick_cyc.size()), 64'd0);
    pulse(800);
    base_a = last_fall;
    expect_rev("resume", base_a, 100, 8);
    check("resume_extra", 64'(tick_cyc.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
